// File: rtl/toll_transaction_ctrl_if.sv
// Bundle between the toll sequencer, the tag-reader stage and the balance RAM.
// The slave modport is the controller's view; the master modport drives requests and RAM read data.
interface toll_transaction_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) ();
    logic                  vehicle_valid;
    logic [ADDR_WIDTH-1:0] vehicle_id;
    logic                  busy;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  done;
    logic                  gate_open;
    logic                  insufficient;
    logic [DATA_WIDTH-1:0] new_balance;
    logic [15:0]           pass_count;

    modport slave (
        input  vehicle_valid, vehicle_id, mem_rdata,
        output busy, mem_addr, mem_we, mem_wdata,
        output done, gate_open, insufficient, new_balance, pass_count
    );

    modport master (
        output vehicle_valid, vehicle_id, mem_rdata,
        input  busy, mem_addr, mem_we, mem_wdata,
        input  done, gate_open, insufficient, new_balance, pass_count
    );
endinterface

// File: rtl/toll_transaction_ctrl.sv
// Read-check-write toll sequencer: 3 edges accept-to-done on grant, 2 on refusal.
// Requests arriving while busy are dropped; the upstream stage must hold or retry.
module toll_transaction_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 4,
    parameter int TOLL_AMOUNT = 50
) (
    input  logic                  clk,
    input  logic                  rst,
    toll_transaction_ctrl_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_WRITE = 2'd3;

    localparam logic [DATA_WIDTH-1:0] TOLL = DATA_WIDTH'(TOLL_AMOUNT);

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  done;
    logic                  gate_open;
    logic                  insufficient;
    logic [DATA_WIDTH-1:0] new_balance;
    logic [15:0]           pass_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            mem_addr     <= '0;
            mem_we       <= 1'b0;
            mem_wdata    <= '0;
            done         <= 1'b0;
            gate_open    <= 1'b0;
            insufficient <= 1'b0;
            new_balance  <= '0;
            pass_count   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.vehicle_valid) begin
                        mem_addr     <= bus.vehicle_id;
                        gate_open    <= 1'b0;
                        insufficient <= 1'b0;
                        state        <= S_READ;
                    end
                end
                S_READ: begin
                    state <= S_CHECK;
                end
                S_CHECK: begin
                    // The compare guards the subtraction, so no underflow is possible.
                    if (bus.mem_rdata >= TOLL) begin
                        mem_we    <= 1'b1;
                        mem_wdata <= bus.mem_rdata - TOLL;
                        state     <= S_WRITE;
                    end else begin
                        insufficient <= 1'b1;
                        new_balance  <= bus.mem_rdata;
                        done         <= 1'b1;
                        state        <= S_IDLE;
                    end
                end
                default: begin
                    mem_we      <= 1'b0;
                    gate_open   <= 1'b1;
                    new_balance <= mem_wdata;
                    done        <= 1'b1;
                    pass_count  <= pass_count + 16'd1;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy         = (state != S_IDLE);
    assign bus.mem_addr     = mem_addr;
    assign bus.mem_we       = mem_we;
    assign bus.mem_wdata    = mem_wdata;
    assign bus.done         = done;
    assign bus.gate_open    = gate_open;
    assign bus.insufficient = insufficient;
    assign bus.new_balance  = new_balance;
    assign bus.pass_count   = pass_count;
endmodule

// File: tb/tb_toll_transaction_ctrl.sv
// Directed bench for toll_transaction_ctrl with a behavioural synchronous-read balance RAM.
module tb_toll_transaction_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    toll_transaction_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) tif ();

    toll_transaction_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .TOLL_AMOUNT(50)) dut (
        .clk (clk),
        .rst (rst),
        .bus (tif.slave)
    );

    // Balance RAM: registered read, write on we; bench preloads through pre_we.
    logic [7:0] ram [16];
    logic [7:0] rdata_q = 8'd0;
    logic       pre_we = 1'b0;
    logic [3:0] pre_addr = 4'd0;
    logic [7:0] pre_data = 8'd0;

    always @(posedge clk) begin
        if (pre_we)
            ram[pre_addr] <= pre_data;
        else if (tif.mem_we)
            ram[tif.mem_addr] <= tif.mem_wdata;
        rdata_q <= ram[tif.mem_addr];
    end
    assign tif.mem_rdata = rdata_q;

    task automatic poke(input logic [3:0] a, input logic [7:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        @(negedge clk);
        pre_we   = 1'b0;
    endtask

    // Called at a negedge; the request is accepted on the following posedge.
    task automatic accept(input logic [3:0] id);
        tif.vehicle_valid = 1'b1;
        tif.vehicle_id    = id;
        @(negedge clk);
        tif.vehicle_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int we_cnt);
        lat = 0;
        we_cnt = 0;
        while (!tif.done && lat < 10) begin
            if (tif.mem_we) we_cnt++;
            @(negedge clk);
            lat++;
        end
        checks++;
        if (!tif.done) begin
            failures++;
            $display("FAIL done_timeout: done=%0b after %0d cycles, required 1", tif.done, lat);
        end
    endtask

    task automatic test_reset();
        tif.vehicle_valid = 1'b0;
        tif.vehicle_id    = 4'd0;
        #1;
        checks++;
        if ({tif.busy, tif.mem_we, tif.done, tif.gate_open, tif.insufficient} !== 5'b0 ||
            tif.mem_addr !== 4'd0 || tif.mem_wdata !== 8'd0 ||
            tif.new_balance !== 8'd0 || tif.pass_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_state: busy=%0b we=%0b done=%0b gate=%0b ins=%0b addr=%0d wdata=%0d bal=%0d cnt=%0d, required all 0",
                     tif.busy, tif.mem_we, tif.done, tif.gate_open, tif.insufficient,
                     tif.mem_addr, tif.mem_wdata, tif.new_balance, tif.pass_count);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_grant();
        int lat, we;
        poke(4'd2, 8'd200);
        accept(4'd2);
        checks++;
        if (tif.busy !== 1'b1) begin
            failures++;
            $display("FAIL grant_busy: busy=%0b, required 1", tif.busy);
        end
        wait_done(lat, we);
        checks++;
        if (lat !== 3 || we !== 1) begin
            failures++;
            $display("FAIL grant_latency: lat=%0d we_cycles=%0d, required 3 and 1", lat, we);
        end
        checks++;
        if (tif.gate_open !== 1'b1 || tif.insufficient !== 1'b0 || tif.new_balance !== 8'd150 ||
            tif.pass_count !== 16'd1 || ram[2] !== 8'd150 || tif.busy !== 1'b0) begin
            failures++;
            $display("FAIL grant_result: gate=%0b ins=%0b bal=%0d cnt=%0d ram2=%0d busy=%0b, required 1 0 150 1 150 0",
                     tif.gate_open, tif.insufficient, tif.new_balance, tif.pass_count, ram[2], tif.busy);
        end
        @(negedge clk);
        checks++;
        if (tif.done !== 1'b0 || tif.gate_open !== 1'b1) begin
            failures++;
            $display("FAIL grant_hold: done=%0b gate=%0b, required 0 1", tif.done, tif.gate_open);
        end
    endtask

    task automatic test_refuse();
        int lat, we;
        poke(4'd1, 8'd40);
        accept(4'd1);
        checks++;
        if (tif.gate_open !== 1'b0 || tif.insufficient !== 1'b0) begin
            failures++;
            $display("FAIL refuse_clear: gate=%0b ins=%0b, required 0 0", tif.gate_open, tif.insufficient);
        end
        wait_done(lat, we);
        checks++;
        if (lat !== 2 || we !== 0) begin
            failures++;
            $display("FAIL refuse_latency: lat=%0d we_cycles=%0d, required 2 and 0", lat, we);
        end
        checks++;
        if (tif.insufficient !== 1'b1 || tif.gate_open !== 1'b0 || tif.new_balance !== 8'd40 ||
            tif.pass_count !== 16'd1 || ram[1] !== 8'd40) begin
            failures++;
            $display("FAIL refuse_result: ins=%0b gate=%0b bal=%0d cnt=%0d ram1=%0d, required 1 0 40 1 40",
                     tif.insufficient, tif.gate_open, tif.new_balance, tif.pass_count, ram[1]);
        end
        @(negedge clk);
    endtask

    task automatic test_boundary();
        int lat, we;
        poke(4'd4, 8'd50);
        accept(4'd4);
        wait_done(lat, we);
        checks++;
        if (tif.gate_open !== 1'b1 || tif.insufficient !== 1'b0 || tif.new_balance !== 8'd0 ||
            ram[4] !== 8'd0 || tif.pass_count !== 16'd2 || lat !== 3) begin
            failures++;
            $display("FAIL boundary_equal: gate=%0b ins=%0b bal=%0d ram4=%0d cnt=%0d lat=%0d, required 1 0 0 0 2 3",
                     tif.gate_open, tif.insufficient, tif.new_balance, ram[4], tif.pass_count, lat);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat, we;
        poke(4'd2, 8'd200);
        accept(4'd2);
        wait_done(lat, we);
        checks++;
        if (tif.new_balance !== 8'd150 || tif.busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_first: bal=%0d busy=%0b, required 150 0", tif.new_balance, tif.busy);
        end
        accept(4'd2);
        checks++;
        if (tif.busy !== 1'b1 || tif.gate_open !== 1'b0) begin
            failures++;
            $display("FAIL b2b_accept: busy=%0b gate=%0b, required 1 0", tif.busy, tif.gate_open);
        end
        wait_done(lat, we);
        checks++;
        if (tif.new_balance !== 8'd100 || ram[2] !== 8'd100 || tif.pass_count !== 16'd4 || lat !== 3) begin
            failures++;
            $display("FAIL b2b_second: bal=%0d ram2=%0d cnt=%0d lat=%0d, required 100 100 4 3",
                     tif.new_balance, ram[2], tif.pass_count, lat);
        end
        @(negedge clk);
    endtask

    task automatic test_ignore_busy();
        int lat, we;
        poke(4'd0, 8'd100);
        poke(4'd5, 8'd120);
        accept(4'd0);
        accept(4'd5);
        wait_done(lat, we);
        checks++;
        if (ram[0] !== 8'd50 || ram[5] !== 8'd120 || tif.new_balance !== 8'd50 ||
            tif.mem_addr !== 4'd0 || tif.pass_count !== 16'd5 || lat !== 2) begin
            failures++;
            $display("FAIL ignore_busy: ram0=%0d ram5=%0d bal=%0d addr=%0d cnt=%0d lat=%0d, required 50 120 50 0 5 2",
                     ram[0], ram[5], tif.new_balance, tif.mem_addr, tif.pass_count, lat);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (tif.busy !== 1'b0 || ram[5] !== 8'd120) begin
            failures++;
            $display("FAIL ignore_idle: busy=%0b ram5=%0d, required 0 120", tif.busy, ram[5]);
        end
    endtask

    task automatic test_reset_mid();
        int lat, we;
        int done_seen;
        poke(4'd3, 8'd75);
        accept(4'd3);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({tif.busy, tif.mem_we, tif.done, tif.gate_open, tif.insufficient} !== 5'b0 ||
            tif.mem_addr !== 4'd0 || tif.new_balance !== 8'd0 || tif.pass_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_mid_outputs: busy=%0b we=%0b done=%0b gate=%0b ins=%0b addr=%0d bal=%0d cnt=%0d, required all 0",
                     tif.busy, tif.mem_we, tif.done, tif.gate_open, tif.insufficient,
                     tif.mem_addr, tif.new_balance, tif.pass_count);
        end
        done_seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (tif.done) done_seen++;
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (tif.done) done_seen++;
        end
        checks++;
        if (done_seen !== 0 || ram[3] !== 8'd75) begin
            failures++;
            $display("FAIL reset_mid_drop: done_pulses=%0d ram3=%0d, required 0 75", done_seen, ram[3]);
        end
        accept(4'd3);
        wait_done(lat, we);
        checks++;
        if (tif.new_balance !== 8'd25 || tif.gate_open !== 1'b1 || ram[3] !== 8'd25 || tif.pass_count !== 16'd1) begin
            failures++;
            $display("FAIL reset_mid_retry: bal=%0d gate=%0b ram3=%0d cnt=%0d, required 25 1 25 1",
                     tif.new_balance, tif.gate_open, ram[3], tif.pass_count);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_grant();
        test_refuse();
        test_boundary();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
